// File: rtl/ll_fifo_rr_drain_pkg.sv
// ----------------------------------------------------------------------------
// ll_fifo_pkg
// Shared definitions for the linked_list_fifo drain/steer stages.
//   sel_width_f : width of a queue select / tag for a given queue count
//                 (never narrower than 1 bit)
//   qid_t       : queue id type for the default two-queue configuration
// ----------------------------------------------------------------------------
package ll_fifo_pkg;

  // Queue-select width: a single queue still needs a 1-bit tag.
  function automatic int sel_width_f(input int num_fifos);
    if (num_fifos <= 2) begin
      return 1;
    end else begin
      return $clog2(num_fifos);
    end
  endfunction

  localparam int NUM_FIFOS_DEF = 2;
  localparam int SEL_WIDTH_DEF = sel_width_f(NUM_FIFOS_DEF);

  typedef logic [SEL_WIDTH_DEF-1:0] qid_t;

endpackage

// File: rtl/ll_fifo_rr_drain_if.sv
// ----------------------------------------------------------------------------
// ll_fifo_rr_drain_if
// Bundles the FIFO pop side and the tagged valid/ready output stream of the
// drain stage.
//   master : the drain stage (drives pop/pop_sel and the output stream)
//   slave  : the environment (FIFO + downstream consumer)
// Signals:
//   fifo_empty [NUM_FIFOS] per-queue empty        fifo_data [WIDTH] head word
//   pop, pop_sel           pop strobe and queue   out_valid/out_ready handshake
//   out_data [WIDTH]       output word            out_qid  source queue
// ----------------------------------------------------------------------------
interface ll_fifo_rr_drain_if
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = sel_width_f(NUM_FIFOS)
) ();

  logic [NUM_FIFOS-1:0] fifo_empty;
  logic [WIDTH-1:0]     fifo_data;
  logic                 pop;
  logic [SEL_WIDTH-1:0] pop_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_qid;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output pop, pop_sel, out_valid, out_data, out_qid
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  pop, pop_sel, out_valid, out_data, out_qid
  );

endinterface

// File: rtl/ll_fifo_rr_drain_arb.sv
// ----------------------------------------------------------------------------
// rr_arbiter_comb
// Purely combinational round-robin arbiter. Scans req starting at rr_ptr and
// wraps modulo NUM_FIFOS (correct for non-power-of-2 counts).
//   req_i    [NUM_FIFOS] request vector
//   rr_ptr_i [SEL_WIDTH] highest-priority index, must be < NUM_FIFOS
//   any_o                at least one request
//   winner_o [SEL_WIDTH] granted index, 0 when nothing requests
// ----------------------------------------------------------------------------
module rr_arbiter_comb
  import ll_fifo_pkg::*;
#(
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = sel_width_f(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req_i,
  input  logic [SEL_WIDTH-1:0] rr_ptr_i,
  output logic                 any_o,
  output logic [SEL_WIDTH-1:0] winner_o
);

  // First requester at or after rr_ptr, wrapping by subtraction rather than
  // a bit-mask so odd queue counts rotate correctly.
  always_comb begin
    int idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    winner_o = {SEL_WIDTH{1'b0}};
    for (int k = 0; k < NUM_FIFOS; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_FIFOS) begin
        idx = idx - NUM_FIFOS;
      end else begin
        idx = idx;
      end
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_o = SEL_WIDTH'(idx);
      end else begin
        found    = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ll_fifo_rr_drain.sv
// ----------------------------------------------------------------------------
// ll_fifo_rr_drain
// Drain stage for the shared linked_list_fifo: round-robin pops among the
// non-empty, enabled queues into a 2-entry skid buffer presented as a tagged
// valid/ready stream. An empty queue is never popped.
//   clk, rst        clock, synchronous active-low reset
//   bus (master)    FIFO pop side + output stream (see ll_fifo_rr_drain_if)
//   en_mask  in     per-queue drain enable
//   pop_cnt  out    total pops since reset, wrapping
//   busy     out    buffer holds data or a queue is eligible
// ----------------------------------------------------------------------------
module ll_fifo_rr_drain
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = sel_width_f(NUM_FIFOS),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ll_fifo_rr_drain_if.master   bus,
  input  logic [NUM_FIFOS-1:0] en_mask,
  output logic [CNT_WIDTH-1:0] pop_cnt,
  output logic                 busy
);

  localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_FIFOS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [NUM_FIFOS-1:0] elig_s;
  logic                 any_s;
  logic [SEL_WIDTH-1:0] winner_s;
  logic                 transfer_s;
  logic                 space_s;
  logic                 pop_s;

  logic [SEL_WIDTH-1:0] rr_ptr_q,    rr_ptr_d;
  logic [1:0]           buf_count_q, buf_count_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     head_data_q, head_data_d;
  logic [SEL_WIDTH-1:0] head_qid_q,  head_qid_d;
  logic [WIDTH-1:0]     tail_data_q, tail_data_d;
  logic [SEL_WIDTH-1:0] tail_qid_q,  tail_qid_d;
  logic [CNT_WIDTH-1:0] pop_cnt_q,   pop_cnt_d;

  assign elig_s = ~bus.fifo_empty & en_mask;

  rr_arbiter_comb #(
    .NUM_FIFOS (NUM_FIFOS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req_i    (elig_s),
    .rr_ptr_i (rr_ptr_q),
    .any_o    (any_s),
    .winner_o (winner_s)
  );

  // A full buffer still accepts when its head leaves in the same cycle.
  assign transfer_s = out_valid_q & bus.out_ready;
  assign space_s    = (buf_count_q < 2'd2) | transfer_s;
  assign pop_s      = rst & any_s & space_s;

  assign bus.pop       = pop_s;
  assign bus.pop_sel   = pop_s ? winner_s : {SEL_WIDTH{1'b0}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_data_q;
  assign bus.out_qid   = head_qid_q;
  assign pop_cnt       = pop_cnt_q;
  assign busy          = out_valid_q | any_s;

  // Skid buffer next state: head feeds the output, tail holds the second word.
  always_comb begin
    buf_count_d = buf_count_q;
    head_data_d = head_data_q;
    head_qid_d  = head_qid_q;
    tail_data_d = tail_data_q;
    tail_qid_d  = tail_qid_q;
    case (buf_count_q)
      2'd0: begin
        if (pop_s) begin
          head_data_d = bus.fifo_data;
          head_qid_d  = winner_s;
          buf_count_d = 2'd1;
        end else begin
          buf_count_d = 2'd0;
        end
      end
      2'd1: begin
        case ({pop_s, transfer_s})
          2'b11: begin
            head_data_d = bus.fifo_data;
            head_qid_d  = winner_s;
          end
          2'b10: begin
            tail_data_d = bus.fifo_data;
            tail_qid_d  = winner_s;
            buf_count_d = 2'd2;
          end
          2'b01: begin
            buf_count_d = 2'd0;
          end
          default: begin
            buf_count_d = 2'd1;
          end
        endcase
      end
      2'd2: begin
        if (transfer_s) begin
          head_data_d = tail_data_q;
          head_qid_d  = tail_qid_q;
          if (pop_s) begin
            tail_data_d = bus.fifo_data;
            tail_qid_d  = winner_s;
          end else begin
            buf_count_d = 2'd1;
          end
        end else begin
          buf_count_d = 2'd2;
        end
      end
      default: begin
        buf_count_d = 2'd0;
      end
    endcase
    out_valid_d = (buf_count_d != 2'd0);
  end

  // Pointer moves just past the winner; statistics count every pop.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    pop_cnt_d = pop_cnt_q;
    if (pop_s) begin
      if (winner_s == SEL_LAST) begin
        rr_ptr_d = {SEL_WIDTH{1'b0}};
      end else begin
        rr_ptr_d = winner_s + SEL_ONE;
      end
      pop_cnt_d = pop_cnt_q + CNT_ONE;
    end else begin
      rr_ptr_d  = rr_ptr_q;
      pop_cnt_d = pop_cnt_q;
    end
  end

  // State registers; reset drops any buffered words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q    <= {SEL_WIDTH{1'b0}};
      buf_count_q <= 2'd0;
      out_valid_q <= 1'b0;
      head_data_q <= {WIDTH{1'b0}};
      head_qid_q  <= {SEL_WIDTH{1'b0}};
      tail_data_q <= {WIDTH{1'b0}};
      tail_qid_q  <= {SEL_WIDTH{1'b0}};
      pop_cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      buf_count_q <= buf_count_d;
      out_valid_q <= out_valid_d;
      head_data_q <= head_data_d;
      head_qid_q  <= head_qid_d;
      tail_data_q <= tail_data_d;
      tail_qid_q  <= tail_qid_d;
      pop_cnt_q   <= pop_cnt_d;
    end
  end

endmodule

// File: doc/ll_fifo_rr_drain.md
Name: ll_fifo_rr_drain

Overview:
Downstream drain stage for the shared linked_list_fifo. It arbitrates round-robin among the non-empty, enabled queues and drives the FIFO's pop/pop_sel. Each popped word is captured into a 2-entry output skid buffer and presented on a valid/ready interface, tagged with its queue id. It also keeps the free-list slot count consistent by never popping an empty queue, which satisfies the "no pop on empty" environment constraint by construction.

Parameters:
WIDTH, 8, data word width (matches linked_list_fifo WIDTH)
NUM_FIFOS, 2, number of logical queues in the shared FIFO
SEL_WIDTH, $clog2(NUM_FIFOS), queue-select / tag width (min 1)
CNT_WIDTH, 16, width of the total-pop statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
fifo_empty  in  NUM_FIFOS  per-queue empty from linked_list_fifo
fifo_data  in  WIDTH  head word of queue pop_sel (combinational, valid when that queue is non-empty)
en_mask  in  NUM_FIFOS  per-queue drain enable; 0 excludes the queue from arbitration
pop  out  1  pop strobe to linked_list_fifo (combinational)
pop_sel  out  SEL_WIDTH  queue being popped (combinational; equals rr winner, 0 when no grant)
out_valid  out  1  output word available
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  WIDTH  output word
out_qid  out  SEL_WIDTH  source queue of out_data
pop_cnt  out  CNT_WIDTH  total pops since reset, wrapping
busy  out  1  buffer non-empty or any eligible queue

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-low. While rst==0: pop=0, pop_sel=0, and on the edge rr_ptr<=0, buf_count<=0, out_valid<=0, out_data<=0, out_qid<=0, pop_cnt<=0. Reset mid-operation discards buffered words. The FIFO is reset by the same rst.
- Eligibility: elig[i] = ~fifo_empty[i] & en_mask[i].
- Grant: the first eligible index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_FIFOS (the modulo must be correct for non-power-of-2 NUM_FIFOS). Purely combinational.
- Space: space = (buf_count<2) | (out_valid & out_ready), i.e. a full buffer can accept in the same cycle it drains.
- pop = rst & (|elig) & space. pop_sel = winner whenever pop is high.
- On a pop edge: write fifo_data and the winner id into the buffer tail, rr_ptr <= (winner+1) mod NUM_FIFOS, pop_cnt <= pop_cnt+1 (wrapping). With no pop, rr_ptr holds.
- Latency: a word popped at edge N has out_valid high after edge N if the buffer was empty. out_data and out_qid are driven from registers, never combinationally from fifo_data.
- Buffer: 2-entry FIFO with head at out_*. out_valid = buf_count!=0. A transfer (out_valid & out_ready) removes the head. Simultaneous pop and transfer keep buf_count unchanged and preserve order.
- Ordering: words from the same queue leave in pop order. Across queues, they leave in grant order.
- out_ready is ignored when out_valid==0. out_data and out_qid are stable while out_valid & ~out_ready.
- Clearing en_mask[i] stops new grants to queue i from the next combinational evaluation. Words already buffered are still delivered.
- busy = out_valid | (|elig).

Decomposition:
- Shared package ll_fifo_pkg: SEL_WIDTH derivation function and the qid typedef.
- One sub-module, rr_arbiter_comb (NUM_FIFOS): inputs req and rr_ptr, outputs any and winner. It is reusable for a future push-side steering stage.
- The skid buffer stays inline.

Test Plan:
- Reset hold: rst=0 for 3 cycles with fifo_empty=2'b00 -> pop=0, out_valid=0, pop_cnt=0. After release, first pop_sel=0.
- Round-robin: both queues non-empty, en_mask=2'b11, out_ready=1 -> pop_sel sequence 0,1,0,1. out_qid follows one cycle later. pop_cnt=4 after 4 pops.
- Backpressure: out_ready=0, queue0 holds 0xA1,0xA2,0xA3 -> 2 pops, then pop=0. out_data holds 0xA1. After out_ready=1, outputs are 0xA1,0xA2,0xA3 in consecutive cycles with no bubble.
- Full-buffer simultaneous: buf_count=2, out_ready=1, queue1 non-empty -> pop=1 in the same cycle and buf_count stays 2.
- Mask/empty skip: fifo_empty=2'b01, en_mask=2'b11 -> only pop_sel=1. With en_mask=2'b01, pop never asserts. pop is never high with the selected queue empty (asserted every cycle).
- Mid-operation reset: rst=0 with buf_count=2 -> next cycle out_valid=0, rr_ptr=0, pop_cnt=0.
